// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants and shared types for the frame reader
package vga_timing_pkg;
    localparam int CNT_W  = 10;
    localparam int ADDR_W = 17;
    localparam int PIX_W  = 16;
    localparam logic [CNT_W-1:0] H_ACTIVE = 10'd640;
    localparam logic [CNT_W-1:0] H_FP     = 10'd16;
    localparam logic [CNT_W-1:0] H_SYNC   = 10'd96;
    localparam logic [CNT_W-1:0] H_BP     = 10'd48;
    localparam logic [CNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CNT_W-1:0] V_ACTIVE = 10'd480;
    localparam logic [CNT_W-1:0] V_FP     = 10'd10;
    localparam logic [CNT_W-1:0] V_SYNC   = 10'd2;
    localparam logic [CNT_W-1:0] V_BP     = 10'd33;
    localparam logic [CNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [CNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [ADDR_W-1:0] SRC_W = 17'd320;
    localparam logic [ADDR_W-1:0] SRC_H = 17'd240;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
    } sync_t;

    // Idle value keeps syncs deasserted so a freshly reset delay line never glitches them low
    localparam sync_t SYNC_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};

    function automatic logic [ADDR_W-1:0] pix_offset(input logic [CNT_W-1:0] h);
        return {{(ADDR_W-CNT_W+1){1'b0}}, h[CNT_W-1:1]};
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x525 h/v counters with counter-aligned active, syncs and frame-start
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic             clk_25MHz,
    input  logic             rst_n,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] h_nxt,
    output logic [CNT_W-1:0] v_nxt,
    output logic             line_end,
    output sync_t            stage0
);
    logic [CNT_W-1:0] h_cnt;

    always_comb begin
        line_end = h_cnt == H_TOTAL - 10'd1;
        h_nxt    = line_end ? '0 : h_cnt + 10'd1;
        v_nxt    = !line_end ? v_cnt : (v_cnt == V_TOTAL - 10'd1) ? '0 : v_cnt + 10'd1;
    end

    assign stage0 = '{
        active: (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE),
        hs:     !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END)),
        vs:     !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END)),
        fs:     (h_cnt == '0) && (v_cnt == '0)
    };

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans the 320x240 frame buffer as 640x480@60 VGA with 2x2 replication,
// aligning syncs, enable and pixel data to the RAM read latency
module vga_frame_reader
    import vga_timing_pkg::*;
#(
    parameter int RD_LATENCY = 2
) (
    input  logic              clk_25MHz,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [PIX_W-1:0]  rddata,
    output logic              vga_enable,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              frame_start
);
    logic [CNT_W-1:0]  v_cnt, h_nxt, v_nxt;
    logic              line_end, act_nxt;
    logic [ADDR_W-1:0] line_base, base_nxt;
    sync_t             stage0, tail;
    sync_t             dly [RD_LATENCY];

    vga_timing_gen u_timing (
        .clk_25MHz (clk_25MHz),
        .rst_n     (rst_n),
        .v_cnt     (v_cnt),
        .h_nxt     (h_nxt),
        .v_nxt     (v_nxt),
        .line_end  (line_end),
        .stage0    (stage0)
    );

    // Address is registered from next-state counters so it lines up with stage 0
    always_comb begin
        act_nxt  = (h_nxt < H_ACTIVE) && (v_nxt < V_ACTIVE);
        base_nxt = !line_end ? line_base
                 : (v_cnt == V_TOTAL - 10'd1) ? '0
                 : ((v_cnt < V_ACTIVE) && v_cnt[0]) ? line_base + SRC_W
                 : line_base;
    end

    assign tail = dly[RD_LATENCY-1];

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            line_base   <= '0;
            rdaddress   <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dly[i] <= SYNC_IDLE;
            vga_enable  <= 1'b0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            frame_start <= 1'b0;
            pixel_data  <= '0;
        end else begin
            line_base   <= base_nxt;
            rdaddress   <= base_nxt + (act_nxt ? pix_offset(h_nxt) : '0);
            dly[0]      <= stage0;
            for (int i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
            vga_enable  <= tail.active;
            vga_hsync   <= tail.hs;
            vga_vsync   <= tail.vs;
            frame_start <= tail.fs;
            pixel_data  <= tail.active ? rddata : '0;
        end
    end
endmodule
